// File: rtl/pipe_seg_adder.sv
// pipe_seg_adder: WIDTH-bit adder resolved SEG bits per pipeline stage, valid/ready with global stall.
// Optional saturation of the registered sum on signed overflow: define PIPE_SEG_ADDER_SAT_EN.
module pipe_seg_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned STAGES = WIDTH / SEG;

    // Slot 0 is the input port side; slot k+1 is the register output of stage k.
    logic [WIDTH-1:0] w_a   [STAGES+1];
    logic [WIDTH-1:0] w_b   [STAGES+1];
    logic [WIDTH-1:0] w_res [STAGES+1];
    logic             w_c   [STAGES+1];
    logic             w_v   [STAGES+1];
    logic             w_ovf [STAGES+1];
    logic             w_adv;

    // Whole pipe shifts together unless a finished result is waiting on downstream.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_v[0]   = in_valid;
    assign w_a[0]   = a;
    assign w_b[0]   = b;
    assign w_c[0]   = cin;
    assign w_res[0] = '0;
    assign w_ovf[0] = 1'b0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SEG;
        localparam int unsigned HI = LO + SEG - 1;

        logic [SEG:0]     w_seg_sum;
        logic [WIDTH-1:0] w_res_nx;
        logic             w_ovf_nx;
        logic             r_v;
        logic             r_c;
        logic             r_ovf;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_res;

        // Resolve segment k; overflow is only meaningful from the top segment.
        always_comb begin
            w_seg_sum = {1'b0, w_a[k][LO +: SEG]} + {1'b0, w_b[k][LO +: SEG]}
                      + (SEG+1)'(w_c[k]);
            w_res_nx            = w_res[k];
            w_res_nx[LO +: SEG] = w_seg_sum[SEG-1:0];
            w_ovf_nx = (w_a[k][HI] == w_b[k][HI]) && (w_seg_sum[SEG-1] != w_a[k][HI]);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_ovf <= 1'b0;
                r_a   <= '0;
                r_b   <= '0;
                r_res <= '0;
            end else if (w_adv) begin
                r_v   <= w_v[k];
                r_c   <= w_seg_sum[SEG];
                r_ovf <= w_ovf_nx;
                r_a   <= w_a[k];
                r_b   <= w_b[k];
                r_res <= w_res_nx;
            end
        end

        assign w_v[k+1]   = r_v;
        assign w_c[k+1]   = r_c;
        assign w_ovf[k+1] = r_ovf;
        assign w_a[k+1]   = r_a;
        assign w_b[k+1]   = r_b;
        assign w_res[k+1] = r_res;
    end

    assign out_valid = w_v[STAGES];
    assign cout      = w_c[STAGES];
    assign ovf       = w_ovf[STAGES];

`ifdef PIPE_SEG_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp after the final register so both builds share the same latency.
    assign sum = !ovf ? w_res[STAGES] : (w_a[STAGES][WIDTH-1] ? SAT_NEG : SAT_POS);
`else
    assign sum = w_res[STAGES];
`endif

endmodule

// File: tb/tb_pipe_seg_adder.sv
// tb_pipe_seg_adder: randomized and directed stimulus against an arithmetic scoreboard.
module tb_pipe_seg_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned SEG   = 4;
    localparam int          LAT   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    pipe_seg_adder #(.WIDTH(WIDTH), .SEG(SEG)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
        int               stl;
    } exp_t;

    exp_t             exp_q[$];
    int               n_chk     = 0;
    int               n_err     = 0;
    int               cyc       = 0;
    int               stall_cnt = 0;
    logic             hold_prev = 1'b0;
    logic [WIDTH-1:0] prev_sum  = '0;
    logic             prev_cout = 1'b0;
    logic             prev_ovf  = 1'b0;
    logic             last_acc  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic ci);
        exp_t        m;
        logic [16:0] full;
        full   = 17'(x) + 17'(y) + 17'(ci);
        m.sum  = full[15:0];
        m.cout = full[16];
        m.ovf  = (x[15] == y[15]) && (full[15] != x[15]);
`ifdef PIPE_SEG_ADDER_SAT_EN
        if (m.ovf) m.sum = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        m.cyc = 0;
        m.stl = 0;
        return m;
    endfunction

    // One clock: evaluate handshakes mid-low-phase, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
        if (hold_prev) begin
            check("hold_sum", 32'(sum), 32'(prev_sum));
            check("hold_flags", 32'({cout, ovf}), 32'({prev_cout, prev_ovf}));
        end
        if (exp_q.size() == 0) check("idle_valid", 32'(out_valid), 32'(0));
        if (out_valid && out_ready && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e.sum));
            check("cout", 32'(cout), 32'(e.cout));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("latency", 32'(cyc - e.cyc - (stall_cnt - e.stl)), 32'(LAT));
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            e     = model(a, b, cin);
            e.cyc = cyc;
            e.stl = stall_cnt;
            exp_q.push_back(e);
        end
        hold_prev = out_valid && !out_ready;
        prev_sum  = sum;
        prev_cout = cout;
        prev_ovf  = ovf;
        if (hold_prev) stall_cnt++;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (last_acc) break;
        end
        if (!last_acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        logic pend;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_flags", 32'({cout, ovf}), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));
        rst = 1'b0;
        @(negedge clk);

        // Directed corner cases, back to back.
        send(16'h1234, 16'h0001, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        // Bubbles: every other slot empty.
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0);
            a        = 16'($urandom);
            b        = 16'($urandom);
            cin      = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Eight back-to-back items with a 3-cycle stall as soon as the first result shows.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
                in_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 60 && !out_valid; n++) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random valid and ready; the source holds an item until it is taken.
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                if ($urandom_range(0, 2) != 0) begin
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    cin      = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    pend     = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            tick();
            if (last_acc) pend = 1'b0;
        end
        out_ready = 1'b1;
        drain();

        // Reset with three items in flight, one already presented.
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        send(16'h5555, 16'h6666, 1'b0);
        in_valid = 1'b0;
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_sum", 32'(sum), 32'(0));
        check("midrst_flags", 32'({cout, ovf}), 32'(0));
        exp_q.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        send(16'h0F0F, 16'h00F1, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_seg_adder.md
# pipe_seg_adder

Parametrised, pipelined segmented adder for the PE datapath. A WIDTH-bit addition is split into SEG-bit segments, one segment resolved per pipeline stage, with the carry registered between stages. This gives one result per clock at a short critical path. It sits between the PE multiplier outputs and the accumulator, uses a valid/ready handshake on both sides with global stall, and reports carry-out and signed overflow. Saturation is optional.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG
- SEG, 4, bits resolved per stage; STAGES = WIDTH/SEG (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a/b/cin valid this cycle
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  operand A (two's complement or unsigned)
- b  in  WIDTH  operand B
- cin  in  1  carry-in to bit 0
- out_valid  out  1  sum/cout/ovf valid
- out_ready  in  1  downstream accepts output
- sum  out  WIDTH  result
- cout  out  1  unsigned carry-out of bit WIDTH-1
- ovf  out  1  signed overflow of a+b+cin

## Operation
- Stage k (k=0..STAGES-1) adds segment k of a and b with the carry from stage k-1. Stage 0 uses cin.
- Unconsumed upper operand segments travel down skew registers. Lower result segments travel down deskew registers, so all WIDTH sum bits exit together.
- Each stage has a valid bit. Bubbles propagate as invalid slots and are not collapsed.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage shifts by one. When adv=0, all stages hold.
- in_ready = adv, combinational. A transfer happens when in_valid && in_ready.
- Final stage registers raw sum, cout, and ovf.
  - ovf = (a[MSB]==b[MSB]) && (raw_sum[MSB]!=a[MSB]). The operand MSBs are carried to the last stage for this.
- Output data is held stable while out_valid && !out_ready.
- Results leave in input order, one per accepted input. None are dropped or duplicated.

## Timing
- Latency: an input accepted at edge N appears with out_valid=1 after edge N+STAGES, absent stalls. For WIDTH=16, SEG=4 the latency is 4 cycles.
- Throughput: 1 result/cycle while out_ready=1.
- Each stall cycle (out_valid && !out_ready) adds exactly one cycle to every in-flight item.
- Reset values: out_valid=0, sum=0, cout=0, ovf=0. All stage valids and data registers are 0. in_ready=1 after reset, since out_valid=0.
- Reset mid-operation: all in-flight items are discarded immediately (asynchronous). No stale result appears after reset deasserts.
- in_valid=1 while in_ready=0: the input is not consumed, and the source must hold it.
- Simultaneous output handshake and input accept in the same cycle: both occur and the pipeline shifts.
- STAGES=1 (SEG=WIDTH): this degenerates to a single registered adder with latency 1.

## Configuration
- PIPE_SEG_ADDER_SAT_EN defined: when ovf=1, sum saturates.
  - Positive overflow (a[MSB]=0) gives 0111…1.
  - Negative overflow gives 1000…0.
  - cout and ovf are still reported raw.
- Not defined: sum is the raw wrap-around result. ovf remains a flag only.
- The saturation mux is applied after the final-stage register, so latency is identical in both builds.

## Test plan
Test plan uses WIDTH=16, SEG=4.
1. Basic add: a=0x1234, b=0x0001, cin=0, out_ready=1 → after 4 cycles, sum=0x1235, cout=0, ovf=0. Carry-in case: a=0, b=0, cin=1 → sum=0x0001.
2. Full carry ripple across all stages: a=0xFFFF, b=0x0001 → sum=0x0000, cout=1, ovf=0.
3. Overflow:
   - a=0x7FFF, b=0x0001 → ovf=1; sum=0x8000 without SAT_EN, 0x7FFF with SAT_EN.
   - a=0x8000, b=0xFFFF → ovf=1, cout=1; sum=0x7FFF without SAT_EN, 0x8000 with SAT_EN.
4. Streaming with backpressure:
   - Send 8 back-to-back random pairs; hold out_ready=0 for 3 cycles once out_valid rises.
   - Expect in_ready=0 during the stall and sum held stable.
   - All 8 results must arrive in order and match the reference model.
5. Bubbles: alternate in_valid 1/0 → out_valid toggles with the same pattern, delayed 4 cycles.
6. Reset mid-flight: assert rst with 3 items in the pipe → out_valid=0 immediately. After release, no output until new input; the first new result has latency 4.
